// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: depth helpers, pointer type and
// the threshold rule used to check the almost-full / almost-empty flags.
package sync_fifo_pkg;

  localparam int DEF_DSIZE = 8;
  localparam int DEF_ASIZE = 4;
  localparam int DEF_DEPTH = 1 << DEF_ASIZE;

  // One extra bit beyond the address so full and empty are distinguishable.
  typedef logic [DEF_ASIZE:0] def_ptr_t;

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  function automatic bit th_flag_ok(input int unsigned cnt, input int unsigned th,
                                    input bit at_or_above, input bit flag);
    bit want;
    want = at_or_above ? (cnt >= th) : (cnt <= th);
    return flag == want;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x DSIZE register array, one synchronous write port and
// one asynchronous read port. Contents are intentionally not reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky
// overflow/underflow flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE     = DEF_DSIZE,
  parameter int ASIZE     = DEF_ASIZE,
  parameter int AFULL_TH  = (1 << ASIZE) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int DEPTH = fifo_depth(ASIZE);

  if (!(AEMPTY_TH > 0 && AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_bad_th
    $error("sync_fifo_ctrl: thresholds must satisfy 0 < AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  typedef logic [ASIZE:0] ptr_t;

  localparam ptr_t DEPTH_C  = ptr_t'(DEPTH);
  localparam ptr_t AFULL_C  = ptr_t'(AFULL_TH);
  localparam ptr_t AEMPTY_C = ptr_t'(AEMPTY_TH);

  ptr_t wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic wfull_q, wfull_d, rempty_q, rempty_d;
  logic walmost_full_q, walmost_full_d, ralmost_empty_q, ralmost_empty_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic wr_acc, rd_acc;
  logic [DSIZE-1:0] mem_rdata;

  // Acceptance is decided on the pre-edge flags; status reflects post-edge occupancy.
  always_comb begin
    wr_acc          = winc && !wfull_q;
    rd_acc          = rinc && !rempty_q;
    wptr_d          = wptr_q + ptr_t'(wr_acc);
    rptr_d          = rptr_q + ptr_t'(rd_acc);
    count_d         = wptr_d - rptr_d;
    wfull_d         = (count_d == DEPTH_C);
    rempty_d        = (count_d == '0);
    walmost_full_d  = (count_d >= AFULL_C);
    ralmost_empty_d = (count_d <= AEMPTY_C);
    // A new error event in the same cycle as clr_err keeps the flag set.
    overflow_d      = (winc && wfull_q)  || (overflow_q  && !clr_err);
    underflow_d     = (rinc && rempty_q) || (underflow_q && !clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      wfull_q         <= 1'b0;
      rempty_q        <= 1'b1;
      walmost_full_q  <= 1'b0;
      ralmost_empty_q <= 1'b1;
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      count_q         <= count_d;
      wfull_q         <= wfull_d;
      rempty_q        <= rempty_d;
      walmost_full_q  <= walmost_full_d;
      ralmost_empty_q <= ralmost_empty_d;
      overflow_q      <= overflow_d;
      underflow_q     <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr_q[ASIZE-1:0]),
    .rdata (mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem_rdata;
`else
  logic [DSIZE-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) rdata_d = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`endif

  assign wfull         = wfull_q;
  assign walmost_full  = walmost_full_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = ralmost_empty_q;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

  a_not_full_and_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(wfull_q && rempty_q));
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= DEPTH_C);
  a_reset_flags: assert property (@(posedge clk)
    !rst_n |-> (!wfull_q && rempty_q));
  a_afull_th: assert property (@(posedge clk) disable iff (!rst_n)
    th_flag_ok(int'(count_q), AFULL_TH, 1'b1, walmost_full_q));
  a_aempty_th: assert property (@(posedge clk) disable iff (!rst_n)
    th_flag_ok(int'(count_q), AEMPTY_TH, 1'b0, ralmost_empty_q));

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomised self-checking bench for sync_fifo_ctrl (default registered-read build),
// compared each cycle against a queue-based reference model.
module tb_sync_fifo_ctrl;

  localparam int DSIZE     = 8;
  localparam int ASIZE     = 4;
  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = 14;
  localparam int AEMPTY_TH = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [DSIZE-1:0] wdata = '0;
  logic             winc = 1'b0;
  logic             rinc = 1'b0;
  logic             clr_err = 1'b0;
  logic             wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
  logic [DSIZE-1:0] rdata;
  logic [ASIZE:0]   count;

  sync_fifo_ctrl #(
    .DSIZE     (DSIZE),
    .ASIZE     (ASIZE),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wdata         (wdata),
    .winc          (winc),
    .wfull         (wfull),
    .walmost_full  (walmost_full),
    .rinc          (rinc),
    .rdata         (rdata),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow),
    .clr_err       (clr_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DSIZE-1:0] model_q[$];
  logic [DSIZE-1:0] exp_rdata = '0;
  bit               exp_ovf = 1'b0;
  bit               exp_unf = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  bit saw_aa   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = model_q.size();
    check_eq("count",         32'(count),         32'(n));
    check_eq("wfull",         32'(wfull),         32'(n == DEPTH));
    check_eq("rempty",        32'(rempty),        32'(n == 0));
    check_eq("walmost_full",  32'(walmost_full),  32'(n >= AFULL_TH));
    check_eq("ralmost_empty", 32'(ralmost_empty), 32'(n <= AEMPTY_TH));
    check_eq("overflow",      32'(overflow),      32'(exp_ovf));
    check_eq("underflow",     32'(underflow),     32'(exp_unf));
    check_eq("rdata",         32'(rdata),         32'(exp_rdata));
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_rdata = '0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  // One clock: drive inputs, advance the model with pre-edge occupancy, check after the edge.
  task automatic step(input bit w, input logic [DSIZE-1:0] d, input bit r, input bit clr);
    bit full, empty;
    winc    = w;
    wdata   = d;
    rinc    = r;
    clr_err = clr;
    @(posedge clk);
    full  = (model_q.size() == DEPTH);
    empty = (model_q.size() == 0);
    if (r && !empty) exp_rdata = model_q.pop_front();
    if (w && !full)  model_q.push_back(d);
    exp_ovf = (w && full)  || (exp_ovf && !clr);
    exp_unf = (r && empty) || (exp_unf && !clr);
    #1;
    if (rdata === 8'hAA) saw_aa = 1'b1;
    check_all();
    winc    = 1'b0;
    rinc    = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Fill 0x01..0x10
    for (int i = 1; i <= DEPTH; i++) step(1'b1, DSIZE'(i), 1'b0, 1'b0);

    // Full: write 0xAA with simultaneous read -> write dropped, read accepted
    step(1'b1, 8'hAA, 1'b1, 1'b0);

    // Drain remaining entries
    while (model_q.size() > 0) step(1'b0, '0, 1'b1, 1'b0);
    check_eq("no_aa_seen", 32'(saw_aa), 32'd0);

    // Empty: read+write 0x55 -> underflow, write accepted
    step(1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    // Read while empty together with clr_err: the set wins
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Sustained read/write at count 8 wraps the pointers several times
    for (int i = 0; i < 8; i++) step(1'b1, DSIZE'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, DSIZE'($urandom), 1'b1, 1'b0);
    while (model_q.size() > 5) step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream at count 5
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic, biased so both full and empty are reached
    for (int i = 0; i < 400; i++) begin
      int phase;
      bit w, r, c;
      phase = (i / 50) % 2;
      w = ($urandom_range(99) < (phase == 0 ? 75 : 25));
      r = ($urandom_range(99) < (phase == 0 ? 25 : 75));
      c = ($urandom_range(99) < 8);
      step(w, DSIZE'($urandom), r, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock, parametrised FIFO with occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the single-clock successor to the team's dual-clock FIFO port set: same `winc`/`wfull`/`rinc`/`rempty` handshake, generalised in width and depth, with extra status. It sits between producer and consumer blocks that share one clock domain.

## Interface
- `DSIZE`, 8, data width in bits
- `ASIZE`, 4, address width; depth DEPTH = 2**ASIZE
- `AFULL_TH`, DEPTH-2, `walmost_full` asserted when count >= AFULL_TH
- `AEMPTY_TH`, 2, `ralmost_empty` asserted when count <= AEMPTY_TH

- `clk`  in  1  single clock; all logic on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `wdata`  in  DSIZE  write data
- `winc`  in  1  write request
- `wfull`  out  1  FIFO full
- `walmost_full`  out  1  count >= AFULL_TH
- `rinc`  in  1  read request
- `rdata`  out  DSIZE  read data
- `rempty`  out  1  FIFO empty
- `ralmost_empty`  out  1  count <= AEMPTY_TH
- `count`  out  ASIZE+1  current occupancy, 0..DEPTH
- `overflow`  out  1  sticky: write attempted while full
- `underflow`  out  1  sticky: read attempted while empty
- `clr_err`  in  1  synchronous clear of both sticky flags

## Operation
- Write is accepted when `winc && !wfull`: `wdata` is stored at `wptr`, and `wptr` increments.
- Read is accepted when `rinc && !rempty`: `rptr` increments.
- `wptr` and `rptr` are ASIZE+1 bits wide and wrap naturally modulo 2*DEPTH. `count = wptr - rptr`, computed with ASIZE+1-bit arithmetic.
- Full and empty decisions use the pre-edge flags. A write while full is dropped and sets `overflow`. A read while empty is ignored and sets `underflow`.
- Simultaneous accepted read and write: count is unchanged, and both pointers advance.
- Write while full with a simultaneous read: the read is accepted, the write is dropped, and `overflow` is set.
- Read while empty with a simultaneous write: the write is accepted, the read is ignored, and `underflow` is set.
- `clr_err` clears both sticky flags. If an error event occurs in the same cycle, the set wins.
- Default read mode: `rdata` is a register loaded with `mem[rptr]` on an accepted read. It is valid the cycle after `rinc` and holds its value otherwise.

## Timing
- Reset values: `wptr`=0, `rptr`=0, `count`=0, `rempty`=1, `ralmost_empty`=1, `wfull`=0, `walmost_full`=0 (for AFULL_TH>0), `overflow`=0, `underflow`=0, `rdata`=0. Memory contents are not reset.
- Status outputs are registered and update on the same edge as the pointers, reflecting post-edge occupancy.
- Write to `rempty` deassert: 1 cycle.
- Read data latency: 1 cycle after accepted `rinc` in default mode.
- Reset asserted mid-operation: all state returns to reset values immediately; data in flight is discarded.
- Parameters must satisfy 0 < AEMPTY_TH < AFULL_TH <= DEPTH. Elaboration fails otherwise.

## Configuration
- `SYNC_FIFO_FWFT_EN` defined: first-word-fall-through mode.
  - `rdata` = `mem[rptr]` combinationally and is valid whenever `!rempty`.
  - `rinc` pops the current word; the next word appears in the same cycle the pointer updates.
  - A write into an empty FIFO is visible on `rdata` 1 cycle after the write edge.
  - `rdata` is undefined while `rempty`=1.
- Not defined: registered 1-cycle read as described under Operation.

## Structure
- Package `sync_fifo_pkg`:
  - `localparam` helpers for DEPTH
  - typedef for the pointer type
  - threshold-check function used by the assertions
- Sub-module `sync_fifo_mem`: DEPTH x DSIZE register array with one write port and one asynchronous read port.
- Controller holds pointers, count, flags and error logic.
- Bound assertions:
  - `wfull` and `rempty` are never both 1.
  - `count` <= DEPTH.
  - `wfull`=0 and `rempty`=1 while `rst_n`=0.

## Test plan
- Reset, then write 0x01..0x10 (DSIZE=8, ASIZE=4) → `wfull`=1 after the 16th write and `count`=16. `walmost_full` rises when count reaches 14.
- Drain all 16 entries → `rdata` sequence 0x01..0x10 (1-cycle lag in default mode). `rempty`=1 and `count`=0 at end. `ralmost_empty` rises at count 2.
- While full, pulse `winc` with 0xAA and `rinc` in the same cycle → `overflow`=1, count stays 16 minus 1 = 15, and 0xAA never appears on `rdata`.
- While empty, assert `rinc` and `winc` (0x55) together → `underflow`=1, `count`=1, next read returns 0x55. A following `clr_err` drives both flags to 0.
- Continuous simultaneous read/write for 40 cycles at count 8 → count holds at 8, pointers wrap past 2*DEPTH, and data order is preserved.
- Assert `rst_n`=0 mid-stream at count 5 → immediate `rempty`=1, `count`=0, flags 0. The first post-reset write is read back correctly.
